reg_operand_fetch: RTL and testbench
====================================

REG_OPERAND_FETCH -- requirements
Module: reg_operand_fetch

Interface
REQ-001 SHALL have: hclk  in  1  clock, rising-edge; reset hrstn, asynchronous, active-low; clock hclk.
REQ-002 SHALL have: hrstn  in  1  asynchronous active-low reset.
REQ-003 SHALL have: dec_valid  in  1 / dec_ready  out  1  decode request handshake.
REQ-004 SHALL have: dec_rs1, dec_rs2, dec_rd  in  5 each; dec_rd_wen  in  1  source/dest indices, dest write intent.
REQ-005 SHALL have: op_valid  out  1 / op_ready  in  1  operand handshake to execute.
REQ-006 SHALL have: op_rs1_data, op_rs2_data  out  32 each; op_rd  out  5; op_rd_wen  out  1.
REQ-007 SHALL have: wb_valid  in  1; wb_rd  in  5; wb_data  in  32  writeback (no ready, always accepted).
REQ-008 SHALL have regfile master ports: reg_waddr out 5, reg_wdata out 32, reg_wen out 1, reg_raddr_1/reg_raddr_2 out 5, reg_ren_1/reg_ren_2 out 1, reg_rdata_1/reg_rdata_2 in 32.
REQ-009 SHALL have: sb_busy  out  1  OR of all scoreboard bits.

Function
REQ-010 States SHALL be IDLE, CHECK, CAPTURE, HOLD.
REQ-011 dec_ready SHALL be 1 only in IDLE; handshake on dec_valid&dec_ready latches rs1/rs2/rd/rd_wen and moves to CHECK.
REQ-012 CHECK: hazard = (rs1!=0 & sb[rs1]) | (rs2!=0 & sb[rs2]), where a bit is treated clear if wb_valid & wb_rd equals that index this cycle.
REQ-013 CHECK with hazard: stay in CHECK, ren_1/ren_2 = 0.
REQ-014 CHECK without hazard: reg_ren_1 = reg_ren_2 = 1, reg_raddr_1/2 = latched rs1/rs2, next state CAPTURE.
REQ-015 CAPTURE: register reg_rdata_1/2 into op_rs1/2_data, op_rd/op_rd_wen from latches; set sb[rd] if rd_wen & rd!=0; next state HOLD.
REQ-016 HOLD: op_valid = 1; op_* stable until op_ready; on op_ready go to IDLE (no back-to-back acceptance in same cycle).
REQ-017 Read latency: ren asserted in CHECK cycle N, rdata sampled at end of cycle N+1; op_valid high from cycle N+2.
REQ-018 Writeback: reg_wen = wb_valid, reg_waddr = wb_rd, reg_wdata = wb_data, combinational pass-through, every cycle regardless of state.
REQ-019 wb_valid SHALL clear sb[wb_rd]; wb_rd = 0 passes through, sb[0] never set.
REQ-020 Simultaneous set (REQ-015) and clear of the same bit SHALL leave the bit set.
REQ-021 Writeback to a non-pending register SHALL be legal and leave scoreboard unchanged apart from REQ-019.
REQ-022 Same-cycle write/read of the same index relies on regfile write-forwarding; no local bypass.
REQ-023 sb_busy SHALL equal |sb, combinational.

Reset
REQ-024 hrstn low SHALL force IDLE, sb = 0, all latches 0, op_* = 0, op_valid = 0, reg_ren_1/2 = 0; dec_ready = 1 after release.
REQ-025 Reset mid-operation SHALL discard the in-flight request and all pending bits without any regfile access.

Structure
REQ-026 Shared package SHALL hold XLEN=32, REG_AW=5, NREGS=32 and the state enum.
REQ-027 Scoreboard SHALL be sub-module reg_scoreboard (set port, clear port, two lookup ports, busy).

Verification
REQ-028 Reset; wb x5=0xDEADBEEF; dec rs1=5 rs2=0 -> op_rs1_data=0xDEADBEEF, op_rs2_data=0, op_valid 2 cycles after CHECK.
REQ-029 dec rd=7 rd_wen=1, consume; dec rs1=7 -> stalls in CHECK, sb_busy=1; wb x7=0x12345678 -> same-cycle ren, op_rs1_data=0x12345678, sb_busy=0.
REQ-030 op_ready held 0 for 5 cycles in HOLD -> op_* stable, dec_ready=0; op_ready=1 -> IDLE next cycle.
REQ-031 dec rd=0 rd_wen=1 -> sb stays 0; wb x0=0xFFFFFFFF -> reg_wen=1, later read of x0 returns 0.
REQ-032 Issue rd=9 in CAPTURE while wb x9 same cycle -> sb[9]=1 after edge.
REQ-033 Assert hrstn low while stalled in CHECK with sb[3]=1 -> IDLE, sb_busy=0, ren=0, op_valid=0.

Source files
------------

// File: rtl/reg_operand_fetch_pkg.sv
// Shared types and sizes for the register operand fetch stage.
// Imported by the fetch top and its scoreboard.
package reg_operand_fetch_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 32;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        CAPTURE,
        HOLD
    } rof_state_e;

endpackage

// File: rtl/reg_operand_fetch_scoreboard.sv
// Pending-writeback scoreboard: one bit per architectural register.
// A same-cycle set and clear of one bit leaves it set; x0 is never pending.
module reg_scoreboard
    import reg_operand_fetch_pkg::*;
(
    input  logic              hclk,
    input  logic              hrstn,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_idx,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_idx,
    input  logic [REG_AW-1:0] lk_idx_1,
    input  logic [REG_AW-1:0] lk_idx_2,
    output logic              lk_pend_1,
    output logic              lk_pend_2,
    output logic              busy
);

    logic [NREGS-1:0] sb_q;
    logic [NREGS-1:0] sb_d;

    always_comb begin
        sb_d = sb_q;
        if (clr_en)
            sb_d[clr_idx] = 1'b0;
        if (set_en)
            sb_d[set_idx] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn)
            sb_q <= '0;
        else
            sb_q <= sb_d;
    end

    // A writeback landing this cycle already resolves the hazard.
    assign lk_pend_1 = (lk_idx_1 != '0) && sb_q[lk_idx_1]
                    && !(clr_en && (clr_idx == lk_idx_1));
    assign lk_pend_2 = (lk_idx_2 != '0) && sb_q[lk_idx_2]
                    && !(clr_en && (clr_idx == lk_idx_2));

    assign busy = |sb_q;

endmodule

// File: rtl/reg_operand_fetch.sv
// Operand fetch stage: stalls on pending writebacks, reads the
// regfile, then holds the operand bundle until execute accepts it.
module reg_operand_fetch
    import reg_operand_fetch_pkg::*;
(
    input  logic              hclk,
    input  logic              hrstn,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_rd_wen,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [XLEN-1:0]   op_rs1_data,
    output logic [XLEN-1:0]   op_rs2_data,
    output logic [REG_AW-1:0] op_rd,
    output logic              op_rd_wen,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [REG_AW-1:0] reg_waddr,
    output logic [XLEN-1:0]   reg_wdata,
    output logic              reg_wen,
    output logic [REG_AW-1:0] reg_raddr_1,
    output logic [REG_AW-1:0] reg_raddr_2,
    output logic              reg_ren_1,
    output logic              reg_ren_2,
    input  logic [XLEN-1:0]   reg_rdata_1,
    input  logic [XLEN-1:0]   reg_rdata_2,
    output logic              sb_busy
);

    rof_state_e        state_q;
    rof_state_e        state_d;
    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;
    logic [REG_AW-1:0] rd_q;
    logic              rd_wen_q;
    logic              pend_1;
    logic              pend_2;
    logic              capture;

    reg_scoreboard u_sb (
        .hclk      (hclk),
        .hrstn     (hrstn),
        .set_en    (capture && rd_wen_q),
        .set_idx   (rd_q),
        .clr_en    (wb_valid),
        .clr_idx   (wb_rd),
        .lk_idx_1  (rs1_q),
        .lk_idx_2  (rs2_q),
        .lk_pend_1 (pend_1),
        .lk_pend_2 (pend_2),
        .busy      (sb_busy)
    );

    always_comb begin
        state_d   = state_q;
        dec_ready = 1'b0;
        reg_ren_1 = 1'b0;
        reg_ren_2 = 1'b0;
        capture   = 1'b0;
        op_valid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                dec_ready = 1'b1;
                if (dec_valid)
                    state_d = CHECK;
            end
            CHECK: begin
                if (!(pend_1 || pend_2)) begin
                    reg_ren_1 = 1'b1;
                    reg_ren_2 = 1'b1;
                    state_d   = CAPTURE;
                end
            end
            CAPTURE: begin
                capture = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                op_valid = 1'b1;
                if (op_ready)
                    state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            rd_wen_q <= 1'b0;
        end else if (dec_valid && dec_ready) begin
            rs1_q    <= dec_rs1;
            rs2_q    <= dec_rs2;
            rd_q     <= dec_rd;
            rd_wen_q <= dec_rd_wen;
        end
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            op_rs1_data <= '0;
            op_rs2_data <= '0;
            op_rd       <= '0;
            op_rd_wen   <= 1'b0;
        end else if (capture) begin
            op_rs1_data <= reg_rdata_1;
            op_rs2_data <= reg_rdata_2;
            op_rd       <= rd_q;
            op_rd_wen   <= rd_wen_q;
        end
    end

    // Same-cycle write/read hazards rely on regfile forwarding.
    assign reg_raddr_1 = rs1_q;
    assign reg_raddr_2 = rs2_q;
    assign reg_wen     = wb_valid;
    assign reg_waddr   = wb_rd;
    assign reg_wdata   = wb_data;

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Testbench for reg_operand_fetch: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_reg_operand_fetch;

    logic        hclk = 1'b0;
    logic        hrstn = 1'b0;
    logic        dec_valid = 1'b0;
    logic        dec_ready;
    logic [4:0]  dec_rs1 = '0;
    logic [4:0]  dec_rs2 = '0;
    logic [4:0]  dec_rd = '0;
    logic        dec_rd_wen = 1'b0;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [31:0] op_rs1_data;
    logic [31:0] op_rs2_data;
    logic [4:0]  op_rd;
    logic        op_rd_wen;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        reg_wen;
    logic [4:0]  reg_raddr_1;
    logic [4:0]  reg_raddr_2;
    logic        reg_ren_1;
    logic        reg_ren_2;
    logic [31:0] reg_rdata_1 = '0;
    logic [31:0] reg_rdata_2 = '0;
    logic        sb_busy;

    int n_checks = 0;
    int n_errors = 0;

    reg_operand_fetch dut (
        .hclk        (hclk),
        .hrstn       (hrstn),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_rd      (dec_rd),
        .dec_rd_wen  (dec_rd_wen),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_rs1_data (op_rs1_data),
        .op_rs2_data (op_rs2_data),
        .op_rd       (op_rd),
        .op_rd_wen   (op_rd_wen),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .reg_waddr   (reg_waddr),
        .reg_wdata   (reg_wdata),
        .reg_wen     (reg_wen),
        .reg_raddr_1 (reg_raddr_1),
        .reg_raddr_2 (reg_raddr_2),
        .reg_ren_1   (reg_ren_1),
        .reg_ren_2   (reg_ren_2),
        .reg_rdata_1 (reg_rdata_1),
        .reg_rdata_2 (reg_rdata_2),
        .sb_busy     (sb_busy)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Regfile with synchronous read and write-forwarding; x0 reads zero.
    logic [31:0] rf [0:31] = '{default: 32'h0};

    function automatic logic [31:0] rf_rd(input logic [4:0] a);
        if (a == 5'd0)
            return 32'h0;
        if (reg_wen && reg_waddr == a)
            return reg_wdata;
        return rf[a];
    endfunction

    always @(posedge hclk) begin
        if (reg_ren_1)
            reg_rdata_1 <= rf_rd(reg_raddr_1);
        if (reg_ren_2)
            reg_rdata_2 <= rf_rd(reg_raddr_2);
        if (reg_wen && reg_waddr != 5'd0)
            rf[reg_waddr] <= reg_wdata;
    end

    // Reference model: one request in flight, read once no source is
    // pending, bundle presented two cycles after the read.
    logic [31:0] m_regs [0:31] = '{default: 32'h0};
    logic [31:0] m_pend = '0;
    logic        m_act = 1'b0;
    logic        m_read = 1'b0;
    int          m_since = 0;
    logic [4:0]  m_rs1 = '0;
    logic [4:0]  m_rs2 = '0;
    logic [4:0]  m_rd = '0;
    logic        m_rwen = 1'b0;
    logic [31:0] m_e1 = '0;
    logic [31:0] m_e2 = '0;

    function automatic logic m_busy_src(input logic [4:0] r);
        return r != 5'd0 && m_pend[r] && !(wb_valid && wb_rd == r);
    endfunction

    function automatic logic m_hazard();
        return m_busy_src(m_rs1) || m_busy_src(m_rs2);
    endfunction

    function automatic logic [31:0] m_val(input logic [4:0] r);
        if (r == 5'd0)
            return 32'h0;
        if (wb_valid && wb_rd == r)
            return wb_data;
        return m_regs[r];
    endfunction

    function automatic logic [31:0] m_pend_next();
        logic [31:0] p;
        p = m_pend;
        if (wb_valid)
            p[wb_rd] = 1'b0;
        if (m_act && m_read && m_since == 1 && m_rwen && m_rd != 5'd0)
            p[m_rd] = 1'b1;
        return p;
    endfunction

    always @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            m_act   <= 1'b0;
            m_read  <= 1'b0;
            m_since <= 0;
            m_pend  <= '0;
            m_rs1   <= '0;
            m_rs2   <= '0;
            m_rd    <= '0;
            m_rwen  <= 1'b0;
        end else begin
            if (!m_act) begin
                if (dec_valid) begin
                    m_act  <= 1'b1;
                    m_read <= 1'b0;
                    m_rs1  <= dec_rs1;
                    m_rs2  <= dec_rs2;
                    m_rd   <= dec_rd;
                    m_rwen <= dec_rd_wen;
                end
            end else if (!m_read) begin
                if (!m_hazard()) begin
                    m_read  <= 1'b1;
                    m_since <= 1;
                    m_e1    <= m_val(m_rs1);
                    m_e2    <= m_val(m_rs2);
                end
            end else if (m_since == 1) begin
                m_since <= 2;
            end else if (op_ready) begin
                m_act <= 1'b0;
            end
            m_pend <= m_pend_next();
            if (wb_valid && wb_rd != 5'd0)
                m_regs[wb_rd] <= wb_data;
        end
    end

    always @(negedge hclk) begin
        logic exp_valid;
        logic exp_ren;
        exp_valid = m_act && m_read && m_since == 2;
        exp_ren   = m_act && !m_read && !m_hazard();
        chk("dec_ready", dec_ready, !m_act);
        chk("op_valid", op_valid, exp_valid);
        if (exp_valid) begin
            chk("op_rs1_data", op_rs1_data, m_e1);
            chk("op_rs2_data", op_rs2_data, m_e2);
            chk("op_rd", op_rd, m_rd);
            chk("op_rd_wen", op_rd_wen, m_rwen);
        end
        chk("sb_busy", sb_busy, |m_pend);
        chk("reg_ren_1", reg_ren_1, exp_ren);
        chk("reg_ren_2", reg_ren_2, exp_ren);
        if (exp_ren) begin
            chk("reg_raddr_1", reg_raddr_1, m_rs1);
            chk("reg_raddr_2", reg_raddr_2, m_rs2);
        end
        chk("reg_wen", reg_wen, wb_valid);
        if (wb_valid) begin
            chk("reg_waddr", reg_waddr, wb_rd);
            chk("reg_wdata", reg_wdata, wb_data);
        end
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wen);
        int n;
        n = 0;
        while (!dec_ready && n < 500) begin
            tick();
            n++;
        end
        chk("dec_ready_timeout", dec_ready, 1'b1);
        dec_valid  = 1'b1;
        dec_rs1    = rs1;
        dec_rs2    = rs2;
        dec_rd     = rd;
        dec_rd_wen = wen;
        tick();
        dec_valid  = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!op_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("op_valid_timeout", op_valid, 1'b1);
    endtask

    task automatic consume();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_rd    = r;
        wb_data  = d;
        tick();
        wb_valid = 1'b0;
    endtask

    initial begin
        int lat;
        logic [31:0] h1;
        logic [31:0] h2;
        logic done;

        repeat (3) tick();
        chk("rst_op_valid", op_valid, 1'b0);
        chk("rst_sb_busy", sb_busy, 1'b0);
        chk("rst_ren", reg_ren_1, 1'b0);
        hrstn = 1'b1;
        tick();
        chk("rst_dec_ready", dec_ready, 1'b1);

        wb(5'd5, 32'hDEADBEEF);
        issue(5'd5, 5'd0, 5'd0, 1'b0);
        wait_valid(lat);
        chk("t1_latency", lat, 2);
        chk("t1_rs1", op_rs1_data, 32'hDEADBEEF);
        chk("t1_rs2", op_rs2_data, 32'h0);
        consume();

        issue(5'd0, 5'd0, 5'd7, 1'b1);
        wait_valid(lat);
        consume();
        issue(5'd7, 5'd0, 5'd0, 1'b0);
        repeat (3) tick();
        chk("t2_stall_busy", sb_busy, 1'b1);
        chk("t2_stall_ren", reg_ren_1, 1'b0);
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        wb_data  = 32'h12345678;
        #1;
        chk("t2_same_cycle_ren", reg_ren_1, 1'b1);
        tick();
        wb_valid = 1'b0;
        chk("t2_busy_clear", sb_busy, 1'b0);
        wait_valid(lat);
        chk("t2_rs1", op_rs1_data, 32'h12345678);

        h1 = op_rs1_data;
        h2 = op_rs2_data;
        repeat (5) begin
            tick();
            chk("t3_hold_rs1", op_rs1_data, h1);
            chk("t3_hold_rs2", op_rs2_data, h2);
            chk("t3_dec_ready", dec_ready, 1'b0);
        end
        consume();
        chk("t3_idle", dec_ready, 1'b1);

        issue(5'd0, 5'd0, 5'd0, 1'b1);
        wait_valid(lat);
        consume();
        chk("t4_x0_busy", sb_busy, 1'b0);
        wb_valid = 1'b1;
        wb_rd    = 5'd0;
        wb_data  = 32'hFFFFFFFF;
        #1;
        chk("t4_x0_wen", reg_wen, 1'b1);
        tick();
        wb_valid = 1'b0;
        issue(5'd0, 5'd0, 5'd0, 1'b0);
        wait_valid(lat);
        chk("t4_x0_read", op_rs1_data, 32'h0);
        consume();

        issue(5'd0, 5'd0, 5'd9, 1'b1);
        tick();
        wb(5'd9, 32'h0000_0099);
        chk("t5_set_wins", sb_busy, 1'b1);
        wait_valid(lat);
        consume();
        wb(5'd9, 32'h0000_0999);
        chk("t5_cleared", sb_busy, 1'b0);

        issue(5'd0, 5'd0, 5'd3, 1'b1);
        wait_valid(lat);
        consume();
        issue(5'd3, 5'd0, 5'd0, 1'b0);
        repeat (2) tick();
        hrstn = 1'b0;
        #1;
        chk("t6_rst_busy", sb_busy, 1'b0);
        chk("t6_rst_ren", reg_ren_1, 1'b0);
        chk("t6_rst_valid", op_valid, 1'b0);
        repeat (2) tick();
        hrstn = 1'b1;
        tick();
        chk("t6_dec_ready", dec_ready, 1'b1);

        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++)
                    issue(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    wb_valid = 1'($urandom_range(0, 1));
                    wb_rd    = 5'($urandom_range(0, 7));
                    wb_data  = $urandom;
                    op_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        wb_valid = 1'b0;
        op_ready = 1'b1;
        repeat (10) tick();
        for (int r = 1; r < 8; r++)
            wb(5'(r), $urandom);
        repeat (3) tick();
        chk("final_idle", dec_ready, 1'b1);
        chk("final_busy", sb_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
